sub_bytes_iter: RTL and testbench
=================================

// Module: sub_bytes_iter
// PURPOSE
//  Parametrised, handshaked AES SubBytes / InvSubBytes unit. Accepts one 128-bit
//  state and substitutes LANES bytes per clock through LANES S-box instances.
//  Trades area for latency: 16/LANES cycles per state. Sits between the round
//  controller and shift_rows in both the encrypt and decrypt datapaths.
// PARAMETERS
//  LANES   4  bytes substituted per cycle; legal values 1,2,4,8,16. Any other value is an elaboration error.
//  INV_EN  1  1: instantiate the inverse S-box table and honour inv_in. 0: forward only, inv_in ignored.
// PORTS
//  clk        in   1    clock, rising edge
//  rst        in   1    synchronous reset, active-high
//  in_valid   in   1    state_in/inv_in are valid
//  in_ready   out  1    block can accept a state (high only in IDLE)
//  state_in   in   128  input state; byte i = bits [8i+7:8i], i=0..15
//  inv_in     in   1    0: forward S-box, 1: inverse S-box (sampled at accept)
//  out_valid  out  1    state_out holds a completed result
//  out_ready  in   1    downstream consumes state_out
//  state_out  out  128  substituted state, same byte mapping as state_in
//  busy       out  1    high in RUN or DONE
// BEHAVIOUR
//  - Reset: FSM=IDLE, group counter=0, work register=0, mode=0; outputs in_ready=1,
//    out_valid=0, state_out=0, busy=0. Reset in any state aborts the transaction and discards it.
//  - N = 16/LANES groups; group g = bytes g*LANES .. g*LANES+LANES-1.
//  - IDLE: in_ready=1. On in_valid&in_ready at edge E0: latch state_in into work
//    register, latch inv_in (forced 0 when INV_EN=0), counter=0, go RUN.
//  - RUN: each edge replaces group[counter] in the work register with its S-box
//    image (forward or inverse per latched mode); counter++. The edge processing
//    group N-1 clears the counter and moves to DONE. out_valid is first high after edge E0+N.
//  - DONE: out_valid=1; state_out=work register, held stable while out_ready=0.
//    On out_valid&out_ready: go IDLE (out_valid=0 next cycle).
//  - No overlap: in_ready=0 in RUN and DONE. Throughput is one state per N+2 cycles
//    at best (accept, N run edges, output handshake, next accept).
//  - in_valid while in_ready=0 has no effect. Changes to state_in/inv_in after
//    accept do not affect the result.
//  - state_out is driven only from the work register (registered output). It
//    shows partial results while in RUN; consumers qualify it with out_valid.
//  - S-box: exact FIPS-197 forward and inverse tables, pure combinational lookup
//    per lane. No default value is reachable because all 256 codes are defined.
//  - Counter width is clog2(N), minimum 1 bit. For LANES=16 RUN lasts exactly one cycle.
// TESTING
//  1. LANES=4, fwd, state_in=128'h193de3bea0f4e22b9ac68d2ae9f84808 -> out_valid 4 edges
//     after accept, state_out=128'hd42711aee0bf98f1b8b45de51e415230.
//  2. Inverse, state_in=128'hd42711aee0bf98f1b8b45de51e415230, inv_in=1 -> state_out =
//     128'h193de3bea0f4e22b9ac68d2ae9f84808. With INV_EN=0, same stimulus -> forward result.
//  3. Corners: all-00 fwd -> all-63; all-63 inv -> all-00; all-FF fwd -> all-16; all-00 inv -> all-52.
//  4. Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and state_out stable,
//     in_ready=0, pending in_valid not taken. Release out_ready -> in_ready=1 on the next cycle;
//     pending state accepted at that cycle's edge.
//  5. Assert rst for one cycle mid-RUN (counter=2) -> next cycle in_ready=1, out_valid=0,
//     state_out=0, busy=0. A following transaction returns the correct result.
//  6. Sweep LANES in {1,2,4,8,16}: latency 16,8,4,2,1. Run 16 transactions covering bytes
//     00..FF in both modes, compare against the golden tables, with random in_valid/out_ready gaps.

Source files
------------

// File: rtl/sub_bytes_iter_if.sv
// Handshake bundle for sub_bytes_iter: one 128-bit state in, one substituted state out.
// The master drives requests and accepts results; the slave is the substitution unit.
interface sub_bytes_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         inv_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         busy;

  modport master (
    output in_valid, state_in, inv_in, out_ready,
    input  in_ready, out_valid, state_out, busy
  );

  modport slave (
    input  in_valid, state_in, inv_in, out_ready,
    output in_ready, out_valid, state_out, busy
  );
endinterface

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes / InvSubBytes: substitutes LANES bytes per clock of a latched
// 128-bit state, then presents the whole result until the consumer takes it.
module sub_bytes_iter #(
  parameter int LANES  = 4,
  parameter bit INV_EN = 1'b1
) (
  input logic          clk,
  input logic          rst,
  sub_bytes_iter_if.slave bus
);
  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_iter: LANES must be one of 1, 2, 4, 8, 16");
  end

  localparam logic [7:0] FWD_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, next_state;
  logic [127:0]       work;
  logic [CW-1:0]      cnt;
  logic               mode;
  logic [6:0]         base;
  logic [8*LANES-1:0] grp_in, grp_out;

  assign base   = 7'(int'(cnt) * 8 * LANES);
  assign grp_in = work[base +: 8*LANES];

  // The inverse table only exists when INV_EN is set; otherwise every lane is forward-only.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] byte_in, fwd;
    assign byte_in = grp_in[8*l +: 8];
    assign fwd     = FWD_SBOX[byte_in];
    if (INV_EN) begin : g_inv
      logic [7:0] inv;
      assign inv = INV_SBOX[byte_in];
      assign grp_out[8*l +: 8] = mode ? inv : fwd;
    end else begin : g_fwd
      assign grp_out[8*l +: 8] = fwd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.in_valid)  next_state = RUN;
      RUN:     if (cnt == LAST)   next_state = DONE;
      DONE:    if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      IDLE:    bus.in_ready  = 1'b1;
      RUN:     bus.busy      = 1'b1;
      DONE:    begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
      end
      default: bus.in_ready  = 1'b0;
    endcase
  end

  // Work register doubles as the output register, so partial results are visible during RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      work <= '0;
      cnt  <= '0;
      mode <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          work <= bus.state_in;
          mode <= INV_EN && bus.inv_in;
          cnt  <= '0;
        end
        RUN: begin
          work[base +: 8*LANES] <= grp_out;
          cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.state_out = work;
endmodule

// File: tb/tb_sub_bytes_iter.sv
// Bench for sub_bytes_iter: one DUT per LANES value plus a forward-only build, checked
// against S-box tables derived from GF(2^8) inversion and the AES affine map.
module tb_sub_bytes_iter;
  localparam int NDUT = 6;
  localparam int LANES_TAB [NDUT] = '{1, 2, 4, 8, 16, 4};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid_a  [NDUT];
  logic [127:0] state_in_a  [NDUT];
  logic         inv_in_a    [NDUT];
  logic         out_ready_a [NDUT];
  logic         in_ready_a  [NDUT];
  logic         out_valid_a [NDUT];
  logic [127:0] state_out_a [NDUT];
  logic         busy_a      [NDUT];

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    sub_bytes_iter_if bus ();
    assign bus.in_valid    = in_valid_a[k];
    assign bus.state_in    = state_in_a[k];
    assign bus.inv_in      = inv_in_a[k];
    assign bus.out_ready   = out_ready_a[k];
    assign in_ready_a[k]   = bus.in_ready;
    assign out_valid_a[k]  = bus.out_valid;
    assign state_out_a[k]  = bus.state_out;
    assign busy_a[k]       = bus.busy;
    sub_bytes_iter #(.LANES(LANES_TAB[k]), .INV_EN(k != NDUT - 1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  int total = 0;
  int bad   = 0;
  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      fwd_tab[x] = s;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[8*i +: 8] = inv ? inv_tab[d[8*i +: 8]] : fwd_tab[d[8*i +: 8]];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offers data until accepted, then scrambles the inputs, measures latency and drains.
  task automatic apply_stimulus(input int k, input logic [127:0] data, input logic inv,
                                input logic [127:0] exp, input int gap_in, input int gap_out,
                                input string tag);
    int w, lat;
    repeat (gap_in) tick();
    in_valid_a[k] = 1'b1;
    state_in_a[k] = data;
    inv_in_a[k]   = inv;
    w = 0;
    while (!in_ready_a[k] && w < 50) begin tick(); w++; end
    if (!in_ready_a[k]) begin
      check_output({tag, " accept"}, 128'(in_ready_a[k]), 128'd1);
      in_valid_a[k] = 1'b0;
      return;
    end
    tick();
    in_valid_a[k] = 1'b0;
    state_in_a[k] = {$urandom, $urandom, $urandom, $urandom};
    inv_in_a[k]   = ~inv;
    check_output({tag, " busy"}, 128'(busy_a[k]), 128'd1);
    lat = 0;
    while (!out_valid_a[k] && lat < 40) begin tick(); lat++; end
    check_output({tag, " latency"}, 128'(lat), 128'(16 / LANES_TAB[k]));
    repeat (gap_out) begin
      check_output({tag, " hold"}, state_out_a[k], exp);
      tick();
    end
    check_output({tag, " result"}, state_out_a[k], exp);
    out_ready_a[k] = 1'b1;
    tick();
    out_ready_a[k] = 1'b0;
    check_output({tag, " drained"}, {126'd0, out_valid_a[k], in_ready_a[k]}, 128'b01);
  endtask

  initial begin
    logic [127:0] d, e, pend;
    int lat;
    for (int k = 0; k < NDUT; k++) begin
      in_valid_a[k] = 1'b0; state_in_a[k] = '0; inv_in_a[k] = 1'b0; out_ready_a[k] = 1'b0;
    end
    build_tables();
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < NDUT; k++)
      check_output($sformatf("reset dut%0d", k),
                   {busy_a[k], out_valid_a[k], in_ready_a[k], state_out_a[k][124:0]},
                   {3'b001, 125'd0});

    apply_stimulus(2, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0,
                   128'hd42711aee0bf98f1b8b45de51e415230, 0, 0, "vec fwd");
    apply_stimulus(2, 128'hd42711aee0bf98f1b8b45de51e415230, 1'b1,
                   128'h193de3bea0f4e22b9ac68d2ae9f84808, 1, 2, "vec inv");
    apply_stimulus(5, 128'hd42711aee0bf98f1b8b45de51e415230, 1'b1,
                   model(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0), 0, 1, "fwd-only inv ignored");

    apply_stimulus(2, {16{8'h00}}, 1'b0, {16{8'h63}}, 0, 0, "corner 00 fwd");
    apply_stimulus(2, {16{8'h63}}, 1'b1, {16{8'h00}}, 0, 0, "corner 63 inv");
    apply_stimulus(2, {16{8'hff}}, 1'b0, {16{8'h16}}, 0, 0, "corner ff fwd");
    apply_stimulus(2, {16{8'h00}}, 1'b1, {16{8'h52}}, 0, 0, "corner 00 inv");

    // Backpressure: result must hold while a second request waits.
    d = {$urandom, $urandom, $urandom, $urandom};
    pend = {$urandom, $urandom, $urandom, $urandom};
    in_valid_a[2] = 1'b1; state_in_a[2] = d; inv_in_a[2] = 1'b0;
    tick();
    state_in_a[2] = pend; inv_in_a[2] = 1'b1;
    lat = 0;
    while (!out_valid_a[2] && lat < 40) begin tick(); lat++; end
    for (int c = 0; c < 10; c++) begin
      check_output($sformatf("bp hold %0d", c),
                   {out_valid_a[2], in_ready_a[2], state_out_a[2]}, {2'b10, model(d, 1'b0)});
      tick();
    end
    out_ready_a[2] = 1'b1;
    tick();
    out_ready_a[2] = 1'b0;
    check_output("bp release ready", 128'(in_ready_a[2]), 128'd1);
    tick();
    in_valid_a[2] = 1'b0;
    check_output("bp pending taken", {126'd0, busy_a[2], in_ready_a[2]}, 128'b10);
    lat = 0;
    while (!out_valid_a[2] && lat < 40) begin tick(); lat++; end
    check_output("bp pending result", state_out_a[2], model(pend, 1'b1));
    out_ready_a[2] = 1'b1; tick(); out_ready_a[2] = 1'b0;

    // Reset two edges into RUN, then a clean transaction.
    in_valid_a[2] = 1'b1; state_in_a[2] = {16{8'h5a}}; inv_in_a[2] = 1'b0;
    tick();
    in_valid_a[2] = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("mid-run reset",
                 {busy_a[2], out_valid_a[2], in_ready_a[2], state_out_a[2][124:0]}, {3'b001, 125'd0});
    d = {$urandom, $urandom, $urandom, $urandom};
    apply_stimulus(2, d, 1'b1, model(d, 1'b1), 0, 0, "after reset");

    // All 256 byte codes in both modes on every lane width, with random gaps.
    for (int k = 0; k < 5; k++)
      for (int m = 0; m < 2; m++)
        for (int t = 0; t < 16; t++) begin
          for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(t * 16 + ((i * 7 + k) % 16));
          e = model(d, m[0]);
          apply_stimulus(k, d, m[0], e, $urandom_range(0, 3), $urandom_range(0, 3),
                         $sformatf("sweep L%0d m%0d t%0d", LANES_TAB[k], m, t));
        end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
